id_stage: RTL and testbench
===========================

// Module: id_stage
// PURPOSE
//  Instruction-decode pipeline stage feeding the ALU. Accepts one fetched RV32I word per
//  valid/ready handshake, decodes opcode/funct3/funct7, register addresses and the
//  sign-extended I-immediate, and flags illegal encodings. Holds the result in a
//  one-entry output register with valid/ready toward execute.
//  Legal classes: OP (7'b0110011) and OP-IMM (7'b0010011); every other opcode is illegal.
// PARAMETERS
//  PC_WIDTH   32  width of i_pc / o_pc
//  CNT_WIDTH  32  width of perf counters (only with ID_PERF_CNT_EN)
// PORTS
//  clk           in   1         single clock, rising edge
//  rst           in   1         synchronous, active-low reset
//  clk_en        in   1         stage enable; low = full hold, no handshakes complete
//  i_flush       in   1         drop held entry; refuse input this cycle
//  i_valid       in   1         fetch word valid
//  o_ready       out  1         stage can accept (combinational)
//  i_instr       in   32        instruction word
//  i_pc          in   PC_WIDTH  PC of i_instr
//  o_valid       out  1         decoded entry valid
//  i_ready       in   1         execute accepts entry
//  o_pc          out  PC_WIDTH  registered PC
//  o_opcode      out  7         instr[6:0]
//  o_funct3      out  3         instr[14:12]
//  o_funct7      out  7         instr[31:25]
//  o_rs1_addr    out  5         instr[19:15]
//  o_rs2_addr    out  5         instr[24:20]; 0 for OP-IMM
//  o_rd_addr     out  5         instr[11:7]
//  o_imm         out  32        sign-extended instr[31:20] for OP-IMM; 0 for OP
//  o_rd_we       out  1         1 iff legal and rd != 0
//  o_illegal     out  1         encoding illegal
//  o_cnt_issued  out  CNT_WIDTH entries accepted by execute (ID_PERF_CNT_EN only)
//  o_cnt_illegal out  CNT_WIDTH illegal entries accepted by execute (ID_PERF_CNT_EN only)
// BEHAVIOUR
//  - Reset (rst==0 at posedge): o_valid=0; every data output and counter = 0. Priority over clk_en.
//  - o_ready = clk_en & ~i_flush & (~o_valid | i_ready). Load when i_valid & o_ready.
//  - Latency: 1 cycle input to o_valid. Full throughput: load and drain in the same cycle.
//  - Drain without load: o_valid->0. Stall (o_valid & ~i_ready): all outputs stable.
//  - clk_en==0: no state change; o_ready=0; execute must not sample o_valid as a transfer.
//  - i_flush & clk_en: o_valid->0 next cycle; input ignored; flush beats load and drain.
//  - Illegal when: opcode not OP/OP-IMM; OP with funct7 not in {00,20}; OP funct7=20
//    with funct3 not in {000,101}; OP-IMM funct3=001 with funct7!=00; OP-IMM funct3=101
//    with funct7 not in {00,20}. Illegal entries still flow (o_illegal=1, o_rd_we=0).
//  - Fields are copied raw, including for illegal words. Sign extension of o_imm uses instr[31].
// CONFIGURATION
//  `ID_PERF_CNT_EN defined: two CNT_WIDTH counters. They increment on o_valid & i_ready & clk_en;
//    the illegal counter also needs o_illegal. Both wrap at 2^CNT_WIDTH with no saturation.
//    Flushed entries are not counted. Reset clears both counters.
//  Undefined: counter ports and logic absent; the interface omits o_cnt_*.
// STRUCTURE
//  rv32_pkg: opcode localparams (OPC_OP, OPC_OP_IMM), FUNCT7_BASE=7'h00, FUNCT7_ALT=7'h20,
//    typedef struct packed decoded_t {opcode,funct3,funct7,rs1,rs2,rd,imm,rd_we,illegal}.
//  Sub-module id_decode: combinational instr->decoded_t. id_stage holds the register and handshake.
// TESTING
//  1 ADD x3,x1,x2 (0x002081B3), i_ready=1 -> next cycle o_valid=1, rs1=1, rs2=2, rd=3, rd_we=1, illegal=0
//  2 ADDI x5,x0,-1 (0xFFF00293) -> o_imm=0xFFFFFFFF, rs2=0, rd=5, rd_we=1
//  3 SRAI x1,x1,3 (0x4030D093) legal; funct7=0x40 on funct3=101 (0x8030D093) -> illegal=1, rd_we=0
//  4 Back-to-back stream, i_ready low 3 cycles -> o_ready=0, outputs stable; no loss or duplication
//  5 i_flush with o_valid=1 and i_valid=1 -> o_valid=0 next cycle, word dropped, counters unchanged
//  6 Reset mid-stall, clk_en=0 -> outputs 0; with ID_PERF_CNT_EN, cnt at all-ones +1 -> 0

Source files
------------

// File: rtl/rv32_pkg.sv
// RV32I decode constants and the decoded-instruction record shared by the ID stage.
package rv32_pkg;

  localparam logic [6:0] OPC_OP      = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM  = 7'b0010011;
  localparam logic [6:0] FUNCT7_BASE = 7'h00;
  localparam logic [6:0] FUNCT7_ALT  = 7'h20;

  typedef struct packed {
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic        rd_we;
    logic        illegal;
  } decoded_t;

endpackage

// File: rtl/id_decode.sv
// Combinational RV32I OP / OP-IMM field extraction and legality check.
module id_decode
  import rv32_pkg::*;
(
  input  logic [31:0] instr,
  output decoded_t    dec
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       f7_base;
  logic       f7_alt;
  logic       illegal;

  assign opcode  = instr[6:0];
  assign funct3  = instr[14:12];
  assign funct7  = instr[31:25];
  assign f7_base = (funct7 == FUNCT7_BASE);
  assign f7_alt  = (funct7 == FUNCT7_ALT);

  always_comb begin
    illegal = 1'b1;
    case (opcode)
      OPC_OP:
        illegal = !(f7_base || (f7_alt && (funct3 == 3'b000 || funct3 == 3'b101)));
      OPC_OP_IMM: begin
        // Only the shift-immediates constrain the upper bits; the rest are plain immediates.
        case (funct3)
          3'b001:  illegal = !f7_base;
          3'b101:  illegal = !(f7_base || f7_alt);
          default: illegal = 1'b0;
        endcase
      end
      default: illegal = 1'b1;
    endcase
  end

  always_comb begin
    dec.opcode  = opcode;
    dec.funct3  = funct3;
    dec.funct7  = funct7;
    dec.rs1     = instr[19:15];
    dec.rs2     = (opcode == OPC_OP_IMM) ? 5'd0 : instr[24:20];
    dec.rd      = instr[11:7];
    dec.imm     = (opcode == OPC_OP) ? 32'd0 : {{20{instr[31]}}, instr[31:20]};
    dec.illegal = illegal;
    dec.rd_we   = !illegal && (instr[11:7] != 5'd0);
  end

endmodule

// File: rtl/id_stage.sv
// Decode stage with a one-entry valid/ready output register toward execute.
// Optional perf counters when ID_PERF_CNT_EN is defined.
module id_stage
  import rv32_pkg::*;
#(
  parameter int PC_WIDTH = 32
`ifdef ID_PERF_CNT_EN
  ,
  parameter int CNT_WIDTH = 32
`endif
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clk_en,
  input  logic                i_flush,
  input  logic                i_valid,
  output logic                o_ready,
  input  logic [31:0]         i_instr,
  input  logic [PC_WIDTH-1:0] i_pc,
  output logic                o_valid,
  input  logic                i_ready,
  output logic [PC_WIDTH-1:0] o_pc,
  output logic [6:0]          o_opcode,
  output logic [2:0]          o_funct3,
  output logic [6:0]          o_funct7,
  output logic [4:0]          o_rs1_addr,
  output logic [4:0]          o_rs2_addr,
  output logic [4:0]          o_rd_addr,
  output logic [31:0]         o_imm,
  output logic                o_rd_we,
  output logic                o_illegal
`ifdef ID_PERF_CNT_EN
  ,
  output logic [CNT_WIDTH-1:0] o_cnt_issued,
  output logic [CNT_WIDTH-1:0] o_cnt_illegal
`endif
);

  decoded_t            dec;
  decoded_t            dec_q;
  logic [PC_WIDTH-1:0] pc_q;
  logic                valid_q;
  logic                load;

  id_decode u_decode (
    .instr (i_instr),
    .dec   (dec)
  );

  assign o_ready = clk_en & ~i_flush & (~valid_q | i_ready);
  assign load    = i_valid & o_ready;

  // Flush wins over both load and drain; clk_en low freezes everything.
  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_q <= 1'b0;
      dec_q   <= '0;
      pc_q    <= '0;
    end else if (clk_en) begin
      if (i_flush) begin
        valid_q <= 1'b0;
      end else if (load) begin
        valid_q <= 1'b1;
        dec_q   <= dec;
        pc_q    <= i_pc;
      end else if (i_ready) begin
        valid_q <= 1'b0;
      end
    end
  end

`ifdef ID_PERF_CNT_EN
  logic [CNT_WIDTH-1:0] cnt_issued_q;
  logic [CNT_WIDTH-1:0] cnt_illegal_q;
  logic                 xfer;

  assign xfer = valid_q & i_ready & clk_en & ~i_flush;

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_issued_q  <= '0;
      cnt_illegal_q <= '0;
    end else if (xfer) begin
      cnt_issued_q <= cnt_issued_q + 1'b1;
      if (dec_q.illegal) cnt_illegal_q <= cnt_illegal_q + 1'b1;
    end
  end

  assign o_cnt_issued  = cnt_issued_q;
  assign o_cnt_illegal = cnt_illegal_q;
`endif

  assign o_valid    = valid_q;
  assign o_pc       = pc_q;
  assign o_opcode   = dec_q.opcode;
  assign o_funct3   = dec_q.funct3;
  assign o_funct7   = dec_q.funct7;
  assign o_rs1_addr = dec_q.rs1;
  assign o_rs2_addr = dec_q.rs2;
  assign o_rd_addr  = dec_q.rd;
  assign o_imm      = dec_q.imm;
  assign o_rd_we    = dec_q.rd_we;
  assign o_illegal  = dec_q.illegal;

endmodule

// File: tb/tb_id_stage.sv
// Directed bench for id_stage: decode fields, legality, handshake, stall, flush, clk_en, reset.
module tb_id_stage;

  localparam int PCW = 32;
`ifdef ID_PERF_CNT_EN
  localparam int CW = 4;
`endif

  logic           clk = 1'b0;
  logic           rst, clk_en, i_flush, i_valid, i_ready;
  logic [31:0]    i_instr;
  logic [PCW-1:0] i_pc;
  logic           o_ready, o_valid, o_rd_we, o_illegal;
  logic [PCW-1:0] o_pc;
  logic [6:0]     o_opcode, o_funct7;
  logic [2:0]     o_funct3;
  logic [4:0]     o_rs1_addr, o_rs2_addr, o_rd_addr;
  logic [31:0]    o_imm;
`ifdef ID_PERF_CNT_EN
  logic [CW-1:0]  o_cnt_issued, o_cnt_illegal;
  int             exp_iss = 0;
  int             exp_ill = 0;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  id_stage #(
    .PC_WIDTH (PCW)
`ifdef ID_PERF_CNT_EN
    , .CNT_WIDTH (CW)
`endif
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .clk_en     (clk_en),
    .i_flush    (i_flush),
    .i_valid    (i_valid),
    .o_ready    (o_ready),
    .i_instr    (i_instr),
    .i_pc       (i_pc),
    .o_valid    (o_valid),
    .i_ready    (i_ready),
    .o_pc       (o_pc),
    .o_opcode   (o_opcode),
    .o_funct3   (o_funct3),
    .o_funct7   (o_funct7),
    .o_rs1_addr (o_rs1_addr),
    .o_rs2_addr (o_rs2_addr),
    .o_rd_addr  (o_rd_addr),
    .o_imm      (o_imm),
    .o_rd_we    (o_rd_we),
    .o_illegal  (o_illegal)
`ifdef ID_PERF_CNT_EN
    , .o_cnt_issued  (o_cnt_issued)
    , .o_cnt_illegal (o_cnt_illegal)
`endif
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Expected counter model follows the stimulus: a transfer happens when the bench
  // presents i_ready on a cycle where it expects a held entry and no flush/hold.
  task automatic tick(input logic exp_hold, input logic exp_ill_entry);
`ifdef ID_PERF_CNT_EN
    if (rst && clk_en && !i_flush && exp_hold && i_ready) begin
      exp_iss++;
      if (exp_ill_entry) exp_ill++;
    end
`endif
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [31:0] instr;
    logic        ill;
    logic        we;
    logic [31:0] imm;
  } vec_t;

  vec_t vecs[9];

  initial begin
    vecs[0] = '{32'h402081B3, 1'b0, 1'b1, 32'h0};        // SUB x3,x1,x2
    vecs[1] = '{32'h402091B3, 1'b1, 1'b0, 32'h0};        // OP f7=20 f3=001
    vecs[2] = '{32'h022081B3, 1'b1, 1'b0, 32'h0};        // OP f7=01
    vecs[3] = '{32'h00109093, 1'b0, 1'b1, 32'h1};        // SLLI x1,x1,1
    vecs[4] = '{32'h40109093, 1'b1, 1'b0, 32'h401};      // SLLI with f7=20
    vecs[5] = '{32'h00002003, 1'b1, 1'b0, 32'h0};        // load opcode
    vecs[6] = '{32'h00000033, 1'b0, 1'b0, 32'h0};        // ADD x0 -> no write
    vecs[7] = '{32'h4030D093, 1'b0, 1'b1, 32'h403};      // SRAI x1,x1,3
    vecs[8] = '{32'h8030D093, 1'b1, 1'b0, 32'hFFFFF803}; // f3=101 f7=40

    rst = 1'b0; clk_en = 1'b1; i_flush = 1'b0; i_valid = 1'b1; i_ready = 1'b1;
    i_instr = 32'h002081B3; i_pc = 32'h100;
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    check("rst_valid", o_valid, 0);
    check("rst_pc", o_pc, 0);
    check("rst_imm", o_imm, 0);
    check("rst_opcode", o_opcode, 0);
    check("rst_rd_we", o_rd_we, 0);

    // ADD x3,x1,x2
    rst = 1'b1;
    #1;
    check("add_o_ready", o_ready, 1);
    tick(1'b0, 1'b0);
    check("add_valid", o_valid, 1);
    check("add_rs1", o_rs1_addr, 1);
    check("add_rs2", o_rs2_addr, 2);
    check("add_rd", o_rd_addr, 3);
    check("add_rd_we", o_rd_we, 1);
    check("add_illegal", o_illegal, 0);
    check("add_pc", o_pc, 32'h100);
    check("add_opcode", o_opcode, 7'h33);

    // ADDI x5,x0,-1
    i_instr = 32'hFFF00293; i_pc = 32'h104;
    tick(1'b1, 1'b0);
    check("addi_imm", o_imm, 32'hFFFFFFFF);
    check("addi_rs2", o_rs2_addr, 0);
    check("addi_rd", o_rd_addr, 5);
    check("addi_rd_we", o_rd_we, 1);
    check("addi_funct7", o_funct7, 7'h7F);

    // Full-throughput stream of legal/illegal encodings
    for (int k = 0; k < 9; k++) begin
      i_instr = vecs[k].instr; i_pc = 32'h1000 + 32'(4 * k);
      tick(1'b1, (k == 0) ? 1'b0 : vecs[k-1].ill);
      check($sformatf("vec%0d_valid", k), o_valid, 1);
      check($sformatf("vec%0d_illegal", k), o_illegal, vecs[k].ill);
      check($sformatf("vec%0d_rd_we", k), o_rd_we, vecs[k].we);
      check($sformatf("vec%0d_imm", k), o_imm, vecs[k].imm);
      check($sformatf("vec%0d_pc", k), o_pc, 32'h1000 + 32'(4 * k));
    end
    i_valid = 1'b0;
    tick(1'b1, vecs[8].ill);
    check("drain_valid", o_valid, 0);

    // Stall: A held while B waits for three cycles
    i_valid = 1'b1; i_instr = 32'h002081B3; i_pc = 32'h200; i_ready = 1'b0;
    tick(1'b0, 1'b0);
    i_instr = 32'h00109093; i_pc = 32'h204;
    for (int c = 0; c < 3; c++) begin
      #1;
      check($sformatf("stall%0d_o_ready", c), o_ready, 0);
      tick(1'b1, 1'b0);
      check($sformatf("stall%0d_pc", c), o_pc, 32'h200);
      check($sformatf("stall%0d_rd", c), o_rd_addr, 3);
      check($sformatf("stall%0d_valid", c), o_valid, 1);
    end
    i_ready = 1'b1;
    #1;
    check("unstall_o_ready", o_ready, 1);
    tick(1'b1, 1'b0);
    check("b_pc", o_pc, 32'h204);
    check("b_rd", o_rd_addr, 1);
    i_valid = 1'b0;
    tick(1'b1, 1'b0);
    check("b_drained", o_valid, 0);

    // Flush with held entry and incoming word
    i_valid = 1'b1; i_instr = 32'h8030D093; i_pc = 32'h300; i_ready = 1'b0;
    tick(1'b0, 1'b0);
    check("c_illegal", o_illegal, 1);
    i_flush = 1'b1; i_instr = 32'h00000293; i_pc = 32'h304; i_ready = 1'b1;
    #1;
    check("flush_o_ready", o_ready, 0);
    tick(1'b1, 1'b1);
    check("flush_valid", o_valid, 0);
    i_flush = 1'b0; i_valid = 1'b0;
    tick(1'b0, 1'b0);
    check("flush_word_dropped", o_valid, 0);
    check("flush_pc_kept", o_pc, 32'h300);
`ifdef ID_PERF_CNT_EN
    check("cnt_issued", o_cnt_issued, exp_iss % (1 << CW));
    check("cnt_illegal", o_cnt_illegal, exp_ill % (1 << CW));
`endif

    // clk_en hold, then reset mid-stall
    i_valid = 1'b1; i_instr = 32'h002081B3; i_pc = 32'h400; i_ready = 1'b0;
    tick(1'b0, 1'b0);
    clk_en = 1'b0; i_ready = 1'b1; i_pc = 32'h404;
    #1;
    check("hold_o_ready", o_ready, 0);
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    check("hold_valid", o_valid, 1);
    check("hold_pc", o_pc, 32'h400);
    rst = 1'b0; i_ready = 1'b0;
    tick(1'b1, 1'b0);
    check("rst2_valid", o_valid, 0);
    check("rst2_pc", o_pc, 0);
    check("rst2_rd", o_rd_addr, 0);
    check("rst2_imm", o_imm, 0);
`ifdef ID_PERF_CNT_EN
    check("rst2_cnt_issued", o_cnt_issued, 0);
    check("rst2_cnt_illegal", o_cnt_illegal, 0);

    // Counter wrap: 2^CW transfers of illegal words bring both counters back to 0
    rst = 1'b1; clk_en = 1'b1; i_ready = 1'b1; i_valid = 1'b1; i_instr = 32'h00002003;
    tick(1'b0, 1'b0);
    for (int n = 0; n < (1 << CW) - 1; n++) tick(1'b1, 1'b1);
    check("cnt_all_ones", o_cnt_issued, (1 << CW) - 1);
    i_valid = 1'b0;
    tick(1'b1, 1'b1);
    check("cnt_issued_wrap", o_cnt_issued, 0);
    check("cnt_illegal_wrap", o_cnt_illegal, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

endmodule
